// File: rtl/mandel_pkg.sv
// Shared Q11.20 fixed-point constants and the scheduler state encoding.
package mandel_pkg;

  localparam int FRAC = 20;
  localparam logic signed [31:0] ONE  = 32'sh0010_0000;
  localparam logic signed [31:0] FOUR = 32'sh0040_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ITER = 2'd2,
    OUT  = 2'd3
  } state_e;

endpackage

// File: rtl/mandel_scheduler_iteration.sv
// Combinational Mandelbrot step: z' = z^2 + c in Q11.20, with escape test |z'|^2 > 4.
module iteration
  import mandel_pkg::*;
(
  input  logic signed [31:0] zr,
  input  logic signed [31:0] zi,
  input  logic signed [31:0] cr,
  input  logic signed [31:0] ci,
  input  logic               lfinished,
  output logic signed [31:0] nzr,
  output logic signed [31:0] nzi,
  output logic               nfinished
);

  logic signed [63:0] zr_w_s, zi_w_s, zr2_s, zi2_s, zri_s;
  logic signed [63:0] nzr_w_s, nzi_w_s, nzr2_s, nzi2_s;
  logic        [63:0] mag_s, limit_s;

  // One step of the recurrence; magnitude is compared at full Q.40 precision.
  always_comb begin
    zr_w_s  = {{32{zr[31]}}, zr};
    zi_w_s  = {{32{zi[31]}}, zi};
    zr2_s   = zr_w_s * zr_w_s;
    zi2_s   = zi_w_s * zi_w_s;
    zri_s   = zr_w_s * zi_w_s;
    nzr     = 32'((zr2_s - zi2_s) >>> FRAC) + cr;
    nzi     = 32'(zri_s >>> (FRAC - 1)) + ci;
    nzr_w_s = {{32{nzr[31]}}, nzr};
    nzi_w_s = {{32{nzi[31]}}, nzi};
    nzr2_s  = nzr_w_s * nzr_w_s;
    nzi2_s  = nzi_w_s * nzi_w_s;
    mag_s   = 64'(nzr2_s) + 64'(nzi2_s);
    limit_s = 64'({{32{FOUR[31]}}, FOUR} * {{32{ONE[31]}}, ONE});
    nfinished = lfinished | (mag_s > limit_s);
  end

endmodule

// File: rtl/mandel_scheduler.sv
// Frame scheduler: walks the pixel raster, runs the step block per pixel and hands results out.
module mandel_scheduler
  import mandel_pkg::*;
#(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int XW     = 10,
  parameter int YW     = 9
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic signed [31:0] cr0,
  input  logic signed [31:0] ci0,
  input  logic signed [31:0] dstep,
  input  logic        [7:0]  max_iter,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XW-1:0]      out_x,
  output logic [YW-1:0]      out_y,
  output logic        [7:0]  out_count,
  output logic               out_inside,
  output logic               busy,
  output logic               done
);

  state_e             state_q, state_d;
  logic [XW-1:0]      x_q, x_d;
  logic [YW-1:0]      y_q, y_d;
  logic signed [31:0] cr_q, cr_d, ci_q, ci_d, zr_q, zr_d, zi_q, zi_d;
  logic signed [31:0] cr0_q, cr0_d, ci0_q, ci0_d, dstep_q, dstep_d;
  logic        [7:0]  max_iter_q, max_iter_d, cnt_q, cnt_d, cnt_inc_s;
  logic        [7:0]  out_count_q, out_count_d;
  logic               out_valid_q, out_valid_d, out_inside_q, out_inside_d;
  logic               busy_q, busy_d, done_q, done_d;
  logic signed [31:0] nzr_s, nzi_s;
  logic               nfin_s;

  iteration u_iteration (
    .zr        (zr_q),
    .zi        (zi_q),
    .cr        (cr_q),
    .ci        (ci_q),
    .lfinished (1'b0),
    .nzr       (nzr_s),
    .nzi       (nzi_s),
    .nfinished (nfin_s)
  );

  assign cnt_inc_s = cnt_q + 8'd1;

  // Next-state and datapath update; abort overrides everything outside IDLE.
  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    cr_d         = cr_q;
    ci_d         = ci_q;
    zr_d         = zr_q;
    zi_d         = zi_q;
    cnt_d        = cnt_q;
    cr0_d        = cr0_q;
    ci0_d        = ci0_q;
    dstep_d      = dstep_q;
    max_iter_d   = max_iter_q;
    out_count_d  = out_count_q;
    out_inside_d = out_inside_q;
    done_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          cr0_d      = cr0;
          ci0_d      = ci0;
          dstep_d    = dstep;
          max_iter_d = max_iter;
          x_d        = '0;
          y_d        = '0;
          cr_d       = cr0;
          ci_d       = ci0;
          state_d    = LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        zr_d  = 32'sd0;
        zi_d  = 32'sd0;
        cnt_d = 8'd0;
        if (max_iter_q == 8'd0) begin
          out_count_d  = 8'd0;
          out_inside_d = 1'b1;
          state_d      = OUT;
        end else begin
          state_d = ITER;
        end
      end
      ITER: begin
        zr_d  = nzr_s;
        zi_d  = nzi_s;
        cnt_d = cnt_inc_s;
        // Escape is tested first so it wins over the iteration limit.
        if (nfin_s) begin
          out_count_d  = cnt_inc_s;
          out_inside_d = 1'b0;
          state_d      = OUT;
        end else if (cnt_inc_s == max_iter_q) begin
          out_count_d  = max_iter_q;
          out_inside_d = 1'b1;
          state_d      = OUT;
        end else begin
          state_d = ITER;
        end
      end
      OUT: begin
        if (out_ready) begin
          if ((x_q == XW'(WIDTH - 1)) && (y_q == YW'(HEIGHT - 1))) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else if (x_q != XW'(WIDTH - 1)) begin
            x_d     = x_q + {{(XW-1){1'b0}}, 1'b1};
            cr_d    = cr_q + dstep_q;
            state_d = LOAD;
          end else begin
            x_d     = '0;
            y_d     = y_q + {{(YW-1){1'b0}}, 1'b1};
            cr_d    = cr0_q;
            ci_d    = ci_q - dstep_q;
            state_d = LOAD;
          end
        end else begin
          state_d = OUT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
      done_d  = 1'b0;
    end else begin
      done_d = done_d;
    end
    out_valid_d = (state_d == OUT);
    busy_d      = (state_d != IDLE);
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      x_q          <= '0;
      y_q          <= '0;
      cr_q         <= 32'sd0;
      ci_q         <= 32'sd0;
      zr_q         <= 32'sd0;
      zi_q         <= 32'sd0;
      cnt_q        <= 8'd0;
      cr0_q        <= 32'sd0;
      ci0_q        <= 32'sd0;
      dstep_q      <= 32'sd0;
      max_iter_q   <= 8'd0;
      out_count_q  <= 8'd0;
      out_inside_q <= 1'b0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      cr_q         <= cr_d;
      ci_q         <= ci_d;
      zr_q         <= zr_d;
      zi_q         <= zi_d;
      cnt_q        <= cnt_d;
      cr0_q        <= cr0_d;
      ci0_q        <= ci0_d;
      dstep_q      <= dstep_d;
      max_iter_q   <= max_iter_d;
      out_count_q  <= out_count_d;
      out_inside_q <= out_inside_d;
      out_valid_q  <= out_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_x      = x_q;
  assign out_y      = y_q;
  assign out_count  = out_count_q;
  assign out_inside = out_inside_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
